// File: rtl/seven_segment_seconds_pkg.sv
// Shared types and constants for the seven-segment seconds counter tile.
package seven_segment_seconds_pkg;

  localparam int unsigned CNT_W_DEF     = 24;
  localparam int unsigned MAX_COUNT_DEF = 10_000_000;
  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned SEG_W         = 7;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Segment patterns, bit0 = a ... bit6 = g, active-high
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seven_segment_seconds_seg7_decoder.sv
// Combinational BCD digit to seven-segment pattern; out-of-range codes blank the display.
module seg7_decoder
  import seven_segment_seconds_pkg::*;
(
  input  digit_t           digit,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_seconds.sv
// Seconds counter tile: prescaled 0..9 digit with toggling decimal point on a seven-segment display.
module seven_segment_seconds
  import seven_segment_seconds_pkg::*;
#(
  parameter int unsigned MAX_COUNT = MAX_COUNT_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned OVR_W = 15;

  logic [CNT_W-1:0] prescaler;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] limit_nxt_c;
  logic [OVR_W-1:0] ovr_c;
  logic             tick_c;
  digit_t           digit;
  logic             dp;
  logic [SEG_W-1:0] seg;

  // Next limit: pin override (zero promoted to one) or the fixed default
  always_comb begin
    ovr_c       = {uio_in, ui_in[7:1]};
    limit_nxt_c = CNT_W'(MAX_COUNT);
    if (ui_in[0]) begin
      limit_nxt_c = (ovr_c == '0) ? CNT_W'(1) : CNT_W'(ovr_c);
    end
  end

  // ">=" so a lowered limit still wraps on the next enabled edge
  assign tick_c = (prescaler >= (limit - CNT_W'(1)));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      prescaler <= '0;
      limit     <= CNT_W'(MAX_COUNT);
      digit     <= '0;
      dp        <= 1'b0;
    end else begin
      limit <= limit_nxt_c;
      if (ena) begin
        if (tick_c) begin
          prescaler <= '0;
          digit     <= (digit == DIGIT_W'(9)) ? '0 : digit + DIGIT_W'(1);
          dp        <= ~dp;
        end else begin
          prescaler <= prescaler + CNT_W'(1);
        end
      end
    end
  end

  seg7_decoder u_dec (
    .digit (digit),
    .seg   (seg)
  );

  assign uo_out  = {dp, seg};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_seven_segment_seconds.sv
// Scoreboard bench for seven_segment_seconds against a per-edge arithmetic reference model.
module tb_seven_segment_seconds;

  localparam int unsigned MAXC = 37;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  seven_segment_seconds #(.MAX_COUNT(MAXC), .CNT_W(24)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int    vectors = 0;
  int    miscompares = 0;
  int    m_p, m_lim, m_digit;
  bit    m_dp;
  string cur_test = "reset";

  logic [23:0] exp_q[$];
  string       name_q[$];

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic void model_reset();
    m_p = 0; m_digit = 0; m_dp = 1'b0; m_lim = MAXC;
  endfunction

  function automatic logic [23:0] model_out();
    return {m_dp, seg_of(m_digit), 16'h0000};
  endfunction

  // One rising edge: tick every `limit` enabled edges, limit takes effect one edge late
  function automatic void model_edge();
    int nl;
    if (rst_n) begin
      model_reset();
    end else begin
      nl = ui_in[0] ? int'({uio_in, ui_in[7:1]}) : int'(MAXC);
      if (nl == 0) nl = 1;
      if (ena) begin
        if (m_p >= m_lim - 1) begin
          m_p = 0;
          m_digit = (m_digit + 1) % 10;
          m_dp = !m_dp;
        end else begin
          m_p++;
        end
      end
      m_lim = nl;
    end
  endfunction

  // Issue n clock edges, pushing the expected response of each
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      exp_q.push_back(model_out());
      name_q.push_back(cur_test);
      #2;
    end
  endtask

  task automatic check_now(input string nm);
    #1;
    vectors++;
    if ({uo_out, uio_out, uio_oe} !== model_out()) begin
      miscompares++;
      $display("FAIL %s: got uo_out=%h uio_out=%h uio_oe=%h, expected %h", nm, uo_out, uio_out,
               uio_oe, model_out());
    end
  endtask

  task automatic assert_reset();
    rst_n = 1'b1;
    model_reset();
    check_now({cur_test, "_async_rst"});
  endtask

  task automatic set_limit(input int lim);
    ui_in  = {7'(lim), 1'b1};
    uio_in = 8'(lim >> 7);
  endtask

  // Monitor: every edge, compare DUT outputs with the oldest expectation
  initial begin
    logic [23:0] e;
    string       nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        vectors++;
        if ({uo_out, uio_out, uio_oe} !== e) begin
          miscompares++;
          $display("FAIL %s: got uo_out=%h uio_out=%h uio_oe=%h, expected uo_out=%h uio_out=%h uio_oe=%h",
                   nm, uo_out, uio_out, uio_oe, e[23:16], e[15:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    int r;
    rst_n = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    model_reset();
    #3;
    check_now("reset_t0");

    cur_test = "reset_hold";
    ui_in = 8'($urandom); uio_in = 8'($urandom); ena = 1'b1;
    cyc(3);

    cur_test = "limit10";
    ui_in = 8'h15; uio_in = 8'h00; ena = 1'b1; rst_n = 1'b0;
    cyc(25);

    cur_test = "wrap";
    assert_reset();
    ui_in = 8'h03; cyc(1);
    rst_n = 1'b0;
    cyc(14);

    cur_test = "ena_gate";
    assert_reset();
    ui_in = 8'h15; cyc(1);
    rst_n = 1'b0;
    cyc(5);
    ena = 1'b0; cyc(20);
    ena = 1'b1; cyc(12);

    cur_test = "zero_limit";
    ui_in = 8'h01; uio_in = 8'h00;
    cyc(12);

    cur_test = "mid_reset";
    assert_reset();
    ui_in = 8'h03; cyc(1);
    rst_n = 1'b0;
    for (int i = 0; i < 20 && m_digit != 7; i++) cyc(1);
    assert_reset();
    cyc(2);
    rst_n = 1'b0;
    cyc(5);

    cur_test = "default_limit";
    ui_in = 8'h00; uio_in = 8'h00;
    cyc(80);

    cur_test = "random";
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (rst_n) begin
        if (r < 30) rst_n = 1'b0;
      end else if (r < 2) begin
        assert_reset();
      end
      ena = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 49) == 0) begin
        r = int'($urandom_range(0, 9));
        if (r < 7)      set_limit(int'($urandom_range(0, 12)));
        else if (r < 8) set_limit(int'($urandom_range(120, 140)));
        else            begin ui_in = {7'($urandom), 1'b0}; uio_in = 8'($urandom); end
      end
      cyc(1);
    end

    cur_test = "drain";
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seven_segment_seconds.md
Name: seven_segment_seconds

Overview:
- Tiny-tile top block that counts seconds 0..9 and shows the digit on a single seven-segment display.
- A free-running prescaler divides the system clock by a limit: either the fixed parameter MAX_COUNT or a value taken from the input pins.
- Each time the prescaler wraps, the displayed digit advances and the decimal point toggles.
- Sits directly under the chip harness with the standard tile pinout.

Parameters:
- MAX_COUNT, 10_000_000, clock cycles per second (10 MHz clock); prescaler limit when the pin override is off.
- CNT_W, 24, prescaler and limit width; MAX_COUNT must fit.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-high (asserted when 1), despite the suffix.
- ena  input  1  tile enable; counting advances only while 1.
- ui_in  input  8  [0] = limit-override enable; [7:1] = limit bits [6:0].
- uio_in  input  8  limit bits [14:7] when the override is on.
- uo_out  output  8  [6:0] = segments a..g, active-high (bit0 = a … bit6 = g); [7] = decimal point.
- uio_out  output  8  constant 0.
- uio_oe  output  8  constant 0 (all bidirectional pins are inputs).

Behaviour:
- Reset (asynchronous, rst_n = 1):
  - prescaler = 0, digit = 0, dp = 0, limit register = MAX_COUNT.
  - Outputs during reset: uo_out = 0x3F (the digit 0, dp off).
- Limit register, reloaded on every clk edge when not in reset:
  - ui_in[0] = 1 → zero-extended {uio_in, ui_in[7:1]} (15 bits); a loaded value of 0 is forced to 1.
  - ui_in[0] = 0 → MAX_COUNT.
  - A change takes effect one cycle after it is sampled.
- Prescaler, when ena = 1 on each clk edge:
  - If prescaler >= limit − 1: prescaler ← 0 and the tick is asserted.
  - Otherwise prescaler ← prescaler + 1.
  - The ">=" compare handles the limit being lowered below the current count: the wrap happens on the next enabled edge.
  - When ena = 0, the prescaler, digit and dp all hold.
- On tick:
  - digit ← (digit == 9) ? 0 : digit + 1, so 9 wraps to 0.
  - dp ← ~dp.
- Timing:
  - One tick every `limit` enabled cycles.
  - The first tick after reset release comes on the `limit`-th enabled edge.
  - With limit = 1, a tick occurs on every enabled edge.
- Segment decode: combinational from the digit register, so uo_out changes in the same cycle the digit register updates.
  - Digits 0..9 → 0x3F, 0x06, 0x5B, 0x4F, 0x66, 0x6D, 0x7D, 0x07, 0x7F, 0x6F.
  - Values 10–15 are unreachable; they decode to 0x00 (blank) for safety.
- digit is 4 bits and dp is 1 bit, both registered.
- Reset asserted mid-count immediately forces the reset values; counting resumes from 0 after release.

Decomposition:
- Shared package holds:
  - the segment-pattern constants SEG_0..SEG_9 and SEG_BLANK;
  - the default MAX_COUNT;
  - the digit type (4-bit).
- One sub-module, seg7_decoder: combinational, 4-bit digit in → 7-bit segment pattern out.
- Prescaler, limit register and digit counter live in the top.

Test Plan:
- Reset: rst_n = 1 with any inputs → uo_out = 0x3F, uio_out = 0x00, uio_oe = 0x00; these hold while reset stays asserted regardless of clk.
- Override limit 10: ui_in = 0x15, uio_in = 0x00, ena = 1, release reset → uo_out[6:0] goes 0x3F → 0x06 after 10 cycles, then → 0x5B after 20; uo_out[7] toggles 0 → 1 → 0.
- Wrap: ui_in = 0x03 (limit 1), ena = 1 → one digit per cycle through 0x3F, 0x06, …, 0x6F, then back to 0x3F on the 10th edge.
- Enable gating: limit 10; drop ena after 5 cycles for 20 cycles, then re-raise it → no segment change while ena = 0; the next change comes 5 enabled cycles after re-enable.
- Zero limit: ui_in = 0x01, uio_in = 0x00 → behaves as limit 1 (digit advances every cycle).
- Mid-operation reset: assert rst_n while showing 7 (0x07) → uo_out = 0x3F immediately, without waiting for a clk edge; counting restarts from 0 after release.
